l1_refill_ctrl: RTL and testbench
=================================

L1_REFILL_CTRL -- requirements
Module: l1_refill_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum MWAIT cycles before an error response; 8-bit range, 1..255.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  CPU load request valid.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_addr  in  64  CPU byte address.
REQ-008 resp_valid  out  1  response valid to CPU.
REQ-009 resp_ready  in  1  CPU accepts the response.
REQ-010 resp_data  out  64  load data.
REQ-011 resp_err  out  1  memory timeout; resp_data = 0 when set.
REQ-012 l1_addr  out  64  address to the L1 array.
REQ-013 l1_we  out  1  L1 write (fill) strobe.
REQ-014 l1_wdata  out  64  L1 fill data.
REQ-015 l1_rdata  in  64  L1 read data, registered, valid one cycle after l1_addr.
REQ-016 l1_hit  in  1  L1 hit, combinational from l1_addr.
REQ-017 mem_req_valid  out  1  memory read request.
REQ-018 mem_req_ready  in  1  memory accepts the request.
REQ-019 mem_addr  out  64  memory read address, req address with bits [3:0] zeroed.
REQ-020 mem_resp_valid  in  1  memory read data valid.
REQ-021 mem_rdata  in  64  memory read data.
REQ-022 hit_cnt, miss_cnt  out  32 each  saturating hit and miss counters.

Function
REQ-023 The FSM SHALL have the states IDLE, LOOKUP, RD, MREQ, MWAIT, FILL and RESP.
REQ-024 req_ready SHALL be 1 only in IDLE; a handshake latches req_addr into addr_q and moves the FSM to LOOKUP.
REQ-025 l1_addr SHALL equal addr_q in every state except IDLE, where it equals req_addr.
REQ-026 LOOKUP: l1_hit=1 -> RD, hit_cnt+1; l1_hit=0 -> MREQ, miss_cnt+1.
REQ-027 RD: data_q <= l1_rdata, resp_err_q <= 0, then go to RESP.
REQ-028 MREQ: mem_req_valid=1 and mem_addr stable until mem_req_ready=1; the FSM then goes to MWAIT and clears the timeout counter.
REQ-029 MWAIT: mem_resp_valid=1 -> data_q <= mem_rdata, go to FILL.
REQ-030 MWAIT: otherwise the counter increments; on reaching TIMEOUT the FSM goes to RESP with resp_err_q=1 and data_q=0, with no fill.
REQ-031 FILL: l1_we=1 for exactly one cycle, l1_wdata=data_q, l1_addr=addr_q; the FSM then goes to RESP.
REQ-032 RESP: resp_valid=1 with resp_data/resp_err stable until resp_ready=1; the FSM then goes to IDLE.
REQ-033 Latency from the request handshake edge to resp_valid SHALL be: hit 3 cycles; miss 3 + mem_req wait + mem response wait + 1 cycles.
REQ-034 mem_resp_valid outside MWAIT SHALL be ignored; a response arriving in the same cycle as the TIMEOUT-th count SHALL win (fill, no error).
REQ-035 The counters SHALL saturate at 0xFFFFFFFF with no wrap.
REQ-036 l1_we and mem_req_valid SHALL never be asserted in the same cycle.
REQ-037 Only one request SHALL be outstanding at a time; there is no pipelining.

Reset
REQ-038 rst_n low SHALL immediately force state=IDLE, all counters=0, data_q=0, resp_err_q=0.
REQ-039 While rst_n is low, all outputs SHALL be 0 except req_ready, which is 0 during reset and 1 on the first cycle after release.
REQ-040 Reset during MREQ/MWAIT/FILL SHALL abandon the transaction with no fill or response; a later mem_resp_valid SHALL be ignored.

Verification
REQ-041 Hit: preload the L1 model at 0x1000 with 0xDEAD_BEEF; request 0x1000 -> resp_valid 3 cycles after the handshake, resp_data=0xDEADBEEF, hit_cnt=1, no mem_req_valid.
REQ-042 Miss: empty L1; request 0x2008; mem_req_ready after 2 cycles; mem_resp 4 cycles later with 0x1234 -> mem_addr=0x2000, one l1_we pulse with wdata 0x1234, resp_data=0x1234, miss_cnt=1; a repeat request hits.
REQ-043 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stable, req_ready=0 throughout.
REQ-044 Timeout: TIMEOUT=4, no mem_resp -> resp_err=1, resp_data=0 exactly 4 cycles after MWAIT entry, no l1_we; a late mem_resp_valid is ignored.
REQ-045 Reset mid-miss: assert rst_n=0 in MWAIT -> outputs 0 in the same cycle; after release, a mem_resp_valid pulse produces no l1_we or resp_valid, and counters read 0.
REQ-046 Saturation: force miss_cnt to 0xFFFFFFFE, run two misses -> miss_cnt=0xFFFFFFFF.

Source files
------------

// File: rtl/l1_refill_ctrl.sv
// Single-outstanding L1 load refill controller: probes the L1, on a miss fetches the
// 16-byte-aligned line address from memory, fills the L1 and returns the load data.
//
// state  | meaning
// IDLE   | waiting for a CPU request (req_ready high)
// LOOKUP | L1 probe with the latched address; hit/miss decided here
// RD     | registered L1 read data is captured
// MREQ   | memory read request held until accepted
// MWAIT  | waiting for memory data, bounded by TIMEOUT cycles
// FILL   | one-cycle L1 write of the refilled data
// RESP   | response held until the CPU accepts it
module l1_refill_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    output logic [63:0] l1_addr,
    output logic        l1_we,
    output logic [63:0] l1_wdata,
    input  logic [63:0] l1_rdata,
    input  logic        l1_hit,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_rdata,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        RD     = 3'd2,
        MREQ   = 3'd3,
        MWAIT  = 3'd4,
        FILL   = 3'd5,
        RESP   = 3'd6
    } state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic        resp_err_q, resp_err_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [7:0]  tmo_inc;

    assign tmo_inc = tmo_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            resp_err_q <= 1'b0;
            tmo_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            resp_err_q <= resp_err_d;
            tmo_q      <= tmo_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        resp_err_d = resp_err_q;
        tmo_d      = tmo_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (l1_hit) begin
                    state_d = RD;
                    if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                end else begin
                    state_d = MREQ;
                    if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end
            RD: begin
                data_d     = l1_rdata;
                resp_err_d = 1'b0;
                state_d    = RESP;
            end
            MREQ: begin
                if (mem_req_ready) begin
                    tmo_d   = '0;
                    state_d = MWAIT;
                end
            end
            MWAIT: begin
                // Data arriving on the last allowed cycle still beats the timeout.
                if (mem_resp_valid) begin
                    data_d     = mem_rdata;
                    resp_err_d = 1'b0;
                    state_d    = FILL;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        data_d     = '0;
                        resp_err_d = 1'b1;
                        state_d    = RESP;
                    end
                end
            end
            FILL: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IDLE-state outputs are gated by rst_n so everything reads zero while reset is held.
    always_comb begin
        req_ready     = rst_n && (state_q == IDLE);
        l1_addr       = (state_q == IDLE) ? (rst_n ? req_addr : 64'd0) : addr_q;
        l1_we         = (state_q == FILL);
        l1_wdata      = data_q;
        mem_req_valid = (state_q == MREQ);
        mem_addr      = {addr_q[63:4], 4'b0000};
        resp_valid    = (state_q == RESP);
        resp_data     = data_q;
        resp_err      = resp_err_q;
        hit_cnt       = hit_cnt_q;
        miss_cnt      = miss_cnt_q;
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Directed bench for l1_refill_ctrl: hit, miss with refill, backpressure, timeout,
// reset mid-miss and counter saturation, against a small L1 array model.
module tb_l1_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic [63:0] l1_addr;
    logic        l1_we;
    logic [63:0] l1_wdata;
    logic [63:0] l1_rdata;
    logic        l1_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_addr;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int total = 0;
    int bad   = 0;

    l1_refill_ctrl #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .l1_addr        (l1_addr),
        .l1_we          (l1_we),
        .l1_wdata       (l1_wdata),
        .l1_rdata       (l1_rdata),
        .l1_hit         (l1_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata),
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four-entry fully associative L1 model with a registered read port.
    logic [63:0] m_tag [4];
    logic [63:0] m_dat [4];
    logic [3:0]  m_vld;
    logic [1:0]  m_ptr;
    logic [63:0] hit_dat;
    logic        model_clr;
    logic        pre_we;
    logic [63:0] pre_addr;
    logic [63:0] pre_data;

    always_comb begin
        l1_hit  = 1'b0;
        hit_dat = 64'd0;
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i] && (m_tag[i] == l1_addr)) begin
                l1_hit  = 1'b1;
                hit_dat = m_dat[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        l1_rdata <= hit_dat;
        if (model_clr) begin
            m_vld <= '0;
            m_ptr <= '0;
        end else if (l1_we) begin
            m_tag[m_ptr] <= l1_addr;
            m_dat[m_ptr] <= l1_wdata;
            m_vld[m_ptr] <= 1'b1;
            m_ptr        <= m_ptr + 2'd1;
        end else if (pre_we) begin
            m_tag[m_ptr] <= pre_addr;
            m_dat[m_ptr] <= pre_data;
            m_vld[m_ptr] <= 1'b1;
            m_ptr        <= m_ptr + 2'd1;
        end
    end

    int we_cnt      = 0;
    int memreq_cnt  = 0;
    int resp_cnt    = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (l1_we === 1'b1) we_cnt++;
        if (mem_req_valid === 1'b1) memreq_cnt++;
        if (resp_valid === 1'b1) resp_cnt++;
        if (l1_we === 1'b1 && mem_req_valid === 1'b1) overlap_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge of the first cycle after the handshake edge.
    task automatic issue(input logic [63:0] a);
        @(negedge clk);
        req_addr  = a;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Counts cycles after the handshake cycle until resp_valid is seen (bounded).
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (resp_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    int cyc;
    int n;
    int we_base;
    int mr_base;
    int rs_base;

    initial begin
        rst_n          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = 64'hABC;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 64'd0;
        model_clr      = 1'b1;
        pre_we         = 1'b0;
        pre_addr       = 64'd0;
        pre_data       = 64'd0;

        #1;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_l1_addr", l1_addr, 64'd0);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_counters", {hit_cnt, miss_cnt}, 64'd0);

        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        model_clr = 1'b0;
        pre_we    = 1'b1;
        pre_addr  = 64'h1000;
        pre_data  = 64'hDEAD_BEEF;
        #1;
        chk("rel_req_ready", {63'd0, req_ready}, 64'd1);
        chk("idle_l1_addr", l1_addr, 64'hABC);
        @(negedge clk);
        pre_we = 1'b0;

        // Hit on the preloaded line.
        mr_base = memreq_cnt;
        issue(64'h1000);
        wait_resp(cyc);
        chk("hit_latency", 64'(cyc), 64'd3);
        chk("hit_data", resp_data, 64'hDEAD_BEEF);
        chk("hit_err", {63'd0, resp_err}, 64'd0);
        chk("hit_cnt", {32'd0, hit_cnt}, 64'd1);
        chk("hit_no_memreq", 64'(memreq_cnt - mr_base), 64'd0);
        accept();

        // Miss: request accepted after two MREQ cycles, data on the last MWAIT cycle.
        we_base = we_cnt;
        issue(64'h2008);
        @(negedge clk);
        chk("miss_memreq", {63'd0, mem_req_valid}, 64'd1);
        chk("miss_mem_addr", mem_addr, 64'h2000);
        @(negedge clk);
        chk("miss_memreq_hold", {63'd0, mem_req_valid}, 64'd1);
        chk("miss_mem_addr_hold", mem_addr, 64'h2000);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("mwait_memreq_low", {63'd0, mem_req_valid}, 64'd0);
        repeat (3) @(negedge clk);
        chk("mwait_no_resp", {63'd0, resp_valid}, 64'd0);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h1234;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("fill_we", {63'd0, l1_we}, 64'd1);
        chk("fill_wdata", l1_wdata, 64'h1234);
        chk("fill_addr", l1_addr, 64'h2008);
        @(negedge clk);
        chk("miss_resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("miss_data", resp_data, 64'h1234);
        chk("miss_err", {63'd0, resp_err}, 64'd0);
        chk("miss_cnt", {32'd0, miss_cnt}, 64'd1);
        chk("miss_one_fill", 64'(we_cnt - we_base), 64'd1);

        // Backpressure: response held for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("bp_resp_data", resp_data, 64'h1234);
            chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
        end
        accept();

        // Refilled line now hits.
        issue(64'h2008);
        wait_resp(cyc);
        chk("rehit_latency", 64'(cyc), 64'd3);
        chk("rehit_data", resp_data, 64'h1234);
        chk("rehit_cnts", {hit_cnt, miss_cnt}, {32'd2, 32'd1});
        accept();

        // Timeout: no memory response at all.
        we_base = we_cnt;
        issue(64'h3000);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_latency", 64'(n), 64'd4);
        chk("tmo_err", {63'd0, resp_err}, 64'd1);
        chk("tmo_data", resp_data, 64'd0);
        chk("tmo_no_fill", 64'(we_cnt - we_base), 64'd0);
        chk("tmo_miss_cnt", {32'd0, miss_cnt}, 64'd2);
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h9999;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("late_resp_data", resp_data, 64'd0);
        accept();
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_no_fill", 64'(we_cnt - we_base), 64'd0);
        chk("late_no_resp", {63'd0, resp_valid}, 64'd0);
        chk("late_idle", {63'd0, req_ready}, 64'd1);

        // Reset while waiting for memory.
        issue(64'h4000);
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("mrst_l1_addr", l1_addr, 64'd0);
        chk("mrst_mem_addr", mem_addr, 64'd0);
        chk("mrst_strobes", {61'd0, resp_valid, l1_we, mem_req_valid}, 64'd0);
        chk("mrst_counters", {hit_cnt, miss_cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        we_base = we_cnt;
        rs_base = resp_cnt;
        mem_resp_valid = 1'b1;
        mem_rdata      = 64'h7777;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mrst_no_fill", 64'(we_cnt - we_base), 64'd0);
        chk("mrst_no_resp", 64'(resp_cnt - rs_base), 64'd0);
        chk("mrst_counters_after", {hit_cnt, miss_cnt}, 64'd0);
        chk("mrst_idle", {63'd0, req_ready}, 64'd1);

        // Saturation of the miss counter.
        force dut.miss_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.miss_cnt_q;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            issue(64'h5000 + 64'(k) * 64'h100);
            @(negedge clk);
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b1;
            mem_rdata      = 64'hA0 + 64'(k);
            @(negedge clk);
            mem_resp_valid = 1'b0;
            @(negedge clk);
            chk("sat_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("sat_resp_data", resp_data, 64'hA0 + 64'(k));
            chk("sat_miss_cnt", {32'd0, miss_cnt}, 64'h0000_0000_FFFF_FFFF);
            accept();
        end
        chk("sat_hit_cnt", {32'd0, hit_cnt}, 64'd0);
        chk("no_we_memreq_overlap", 64'(overlap_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
